// File: rtl/state_encoder_if.sv
// Feature-word stream between the state encoder and the MLP input buffer.
// The encoder drives data/index/valid/last; the buffer drives ready.
interface state_encoder_if;
    logic [15:0] feat_data;
    logic [5:0]  feat_idx;
    logic        feat_valid;
    logic        feat_last;
    logic        feat_ready;

    modport master (
        output feat_data,
        output feat_idx,
        output feat_valid,
        output feat_last,
        input  feat_ready
    );

    modport slave (
        input  feat_data,
        input  feat_idx,
        input  feat_valid,
        input  feat_last,
        output feat_ready
    );
endinterface

// File: rtl/state_encoder.sv
// Snapshots integer game state on start, streams N_FEAT fixed-point feature
// words, pulses mlp_start, then stays busy until inference_done.
module state_encoder #(
    parameter int N_FEAT    = 33,
    parameter int FRAC_BITS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   live_left,
    input  logic [3:0]   blank_left,
    input  logic [2:0]   current_index,
    input  logic         saw_active,
    input  logic         reverse_active,
    input  logic         phase_item,
    input  logic         phase_shoot,
    input  logic [3:0]   player_hp,
    input  logic [3:0]   opponent_hp,
    input  logic [27:0]  player_items,
    input  logic [27:0]  opp_items,
    input  logic         opp_handcuffed,
    input  logic         self_handcuffed,
    input  logic [15:0]  knowledge,
    state_encoder_if.master feat,
    output logic         mlp_start,
    input  logic         inference_done,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, STREAM, KICK, WAIT} state_t;

    typedef struct packed {
        logic [3:0]  live;
        logic [3:0]  blank;
        logic [2:0]  cur_idx;
        logic        saw;
        logic        rev;
        logic        ph_item;
        logic        ph_shoot;
        logic [3:0]  p_hp;
        logic [3:0]  o_hp;
        logic [27:0] p_items;
        logic [27:0] o_items;
        logic        o_cuff;
        logic        s_cuff;
        logic [15:0] know;
    } snap_t;

    localparam logic [5:0]  LAST_IDX  = 6'(N_FEAT - 1);
    localparam logic [31:0] SAT_LIMIT = 32'((1 << (15 - FRAC_BITS)) - 1);

    function automatic logic [3:0] feature_int(input snap_t s, input logic [5:0] idx);
        logic [3:0] v;
        logic [4:0] ibase;
        logic [3:0] kbase;
        v     = 4'd0;
        ibase = 5'd0;
        kbase = 4'd0;
        if (idx <= 6'd8) begin
            case (idx)
                6'd0:    v = s.live;
                6'd1:    v = s.blank;
                6'd2:    v = {1'b0, s.cur_idx};
                6'd3:    v = {3'd0, s.saw};
                6'd4:    v = {3'd0, s.rev};
                6'd5:    v = {3'd0, s.ph_item};
                6'd6:    v = {3'd0, s.ph_shoot};
                6'd7:    v = s.p_hp;
                6'd8:    v = s.o_hp;
                default: v = 4'd0;
            endcase
        end else if (idx <= 6'd15) begin
            ibase = 5'((idx - 6'd9) << 2);
            v     = s.p_items[ibase +: 4];
        end else if (idx == 6'd16) begin
            v = {3'd0, s.o_cuff};
        end else if (idx <= 6'd23) begin
            ibase = 5'((idx - 6'd17) << 2);
            v     = s.o_items[ibase +: 4];
        end else if (idx == 6'd24) begin
            v = {3'd0, s.s_cuff};
        end else if (idx <= 6'd32) begin
            kbase = 4'((idx - 6'd25) << 1);
            v     = {2'd0, s.know[kbase +: 2]};
        end else begin
            v = 4'd0;
        end
        return v;
    endfunction

    // Counts too large for the signed fixed-point range clamp to the max positive word.
    function automatic logic [15:0] encode_word(input logic [3:0] v);
        logic [31:0] wide;
        wide = {28'd0, v} << FRAC_BITS;
        if ({28'd0, v} > SAT_LIMIT) begin
            return 16'h7FFF;
        end else begin
            return wide[15:0];
        end
    endfunction

    state_t      state_r, state_s;
    snap_t       snap_r, live_snap_s;
    logic [5:0]  idx_r, idx_s;
    logic [15:0] data_r, data_s;
    logic        valid_r, valid_s;
    logic        last_r, last_s;
    logic        mlp_start_r, mlp_start_s;
    logic        busy_r, busy_s;
    logic        capture_s;

    assign live_snap_s = {live_left, blank_left, current_index, saw_active, reverse_active,
                          phase_item, phase_shoot, player_hp, opponent_hp, player_items,
                          opp_items, opp_handcuffed, self_handcuffed, knowledge};

    // Next-state and next-output computation; word 0 comes from the live inputs on capture.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        data_s      = data_r;
        valid_s     = valid_r;
        mlp_start_s = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    capture_s = 1'b1;
                    idx_s     = 6'd0;
                    data_s    = encode_word(feature_int(live_snap_s, 6'd0));
                    valid_s   = 1'b1;
                    state_s   = STREAM;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (valid_r && feat.feat_ready) begin
                    if (idx_r == LAST_IDX) begin
                        valid_s     = 1'b0;
                        mlp_start_s = 1'b1;
                        state_s     = KICK;
                    end else begin
                        idx_s  = idx_r + 6'd1;
                        data_s = encode_word(feature_int(snap_r, idx_r + 6'd1));
                    end
                end else begin
                    state_s = STREAM;
                end
            end
            KICK: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (inference_done) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
        last_s = valid_s && (idx_s == LAST_IDX);
    end

    // State, output and snapshot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= 6'd0;
            data_r      <= 16'd0;
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            mlp_start_r <= 1'b0;
            busy_r      <= 1'b0;
            snap_r      <= '0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            data_r      <= data_s;
            valid_r     <= valid_s;
            last_r      <= last_s;
            mlp_start_r <= mlp_start_s;
            busy_r      <= busy_s;
            if (capture_s) begin
                snap_r <= live_snap_s;
            end
        end
    end

    assign feat.feat_data  = data_r;
    assign feat.feat_idx   = idx_r;
    assign feat.feat_valid = valid_r;
    assign feat.feat_last  = last_r;
    assign mlp_start       = mlp_start_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_state_encoder.sv
// Directed bench for state_encoder: table of hand-computed feature words plus
// multi-cycle sequences for stalls, snapshot isolation, WAIT release and async reset.
module tb_state_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  live_left, blank_left, player_hp, opponent_hp;
    logic [2:0]  current_index;
    logic        saw_active, reverse_active, phase_item, phase_shoot;
    logic [27:0] player_items, opp_items;
    logic        opp_handcuffed, self_handcuffed;
    logic [15:0] knowledge;
    logic        inference_done;
    logic        feat_ready;
    logic        mlp_start10, busy10, mlp_start12, busy12;

    always #5 clk = ~clk;

    state_encoder_if feat10();
    state_encoder_if feat12();
    assign feat10.feat_ready = feat_ready;
    assign feat12.feat_ready = feat_ready;

    state_encoder #(.N_FEAT(33), .FRAC_BITS(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .live_left(live_left), .blank_left(blank_left), .current_index(current_index),
        .saw_active(saw_active), .reverse_active(reverse_active),
        .phase_item(phase_item), .phase_shoot(phase_shoot),
        .player_hp(player_hp), .opponent_hp(opponent_hp),
        .player_items(player_items), .opp_items(opp_items),
        .opp_handcuffed(opp_handcuffed), .self_handcuffed(self_handcuffed),
        .knowledge(knowledge), .feat(feat10),
        .mlp_start(mlp_start10), .inference_done(inference_done), .busy(busy10)
    );

    state_encoder #(.N_FEAT(33), .FRAC_BITS(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .live_left(live_left), .blank_left(blank_left), .current_index(current_index),
        .saw_active(saw_active), .reverse_active(reverse_active),
        .phase_item(phase_item), .phase_shoot(phase_shoot),
        .player_hp(player_hp), .opponent_hp(opponent_hp),
        .player_items(player_items), .opp_items(opp_items),
        .opp_handcuffed(opp_handcuffed), .self_handcuffed(self_handcuffed),
        .knowledge(knowledge), .feat(feat12),
        .mlp_start(mlp_start12), .inference_done(inference_done), .busy(busy12)
    );

    typedef struct {
        int          scen;
        int          idx;
        logic [15:0] exp10;
        logic [15:0] exp12;
    } vec_t;

    localparam int NTBL = 21;
    vec_t tbl[NTBL];

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp10[33], exp12[33], got10[33], got12[33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic set_scen(input int s);
        live_left = 4'd0; blank_left = 4'd0; current_index = 3'd0;
        saw_active = 1'b0; reverse_active = 1'b0; phase_item = 1'b0; phase_shoot = 1'b0;
        player_hp = 4'd0; opponent_hp = 4'd0; player_items = 28'd0; opp_items = 28'd0;
        opp_handcuffed = 1'b0; self_handcuffed = 1'b0; knowledge = 16'd0;
        case (s)
            0: begin
                live_left = 4'd3; blank_left = 4'd2; player_hp = 4'd4; opponent_hp = 4'd4;
            end
            1: begin
                knowledge = 16'h00E4;
            end
            2: begin
                live_left = 4'd15; blank_left = 4'd5; current_index = 3'd7;
                saw_active = 1'b1; phase_item = 1'b1; player_hp = 4'd15; opponent_hp = 4'd7;
                player_items = 28'h7654321; opp_items = 28'hFEDCBA9;
                opp_handcuffed = 1'b1; knowledge = 16'hFFFF;
            end
            default: begin
                live_left = 4'd1; blank_left = 4'd1; current_index = 3'd1;
                reverse_active = 1'b1; phase_shoot = 1'b1; player_hp = 4'd2; opponent_hp = 4'd2;
                player_items = 28'h1111111; opp_items = 28'h2222222;
                self_handcuffed = 1'b1; knowledge = 16'h5555;
            end
        endcase
    endtask

    function automatic logic [15:0] scale(input int v, input int frac);
        if (v > (2 ** (15 - frac)) - 1) return 16'h7FFF;
        else return 16'(v * (2 ** frac));
    endfunction

    // Expected frame from the inputs currently applied (i.e. what start will capture).
    task automatic build_expected();
        int v[33];
        v[0] = int'(live_left);  v[1] = int'(blank_left); v[2] = int'(current_index);
        v[3] = int'(saw_active); v[4] = int'(reverse_active);
        v[5] = int'(phase_item); v[6] = int'(phase_shoot);
        v[7] = int'(player_hp);  v[8] = int'(opponent_hp);
        for (int j = 0; j < 7; j++) begin
            v[9 + j]  = int'((player_items >> (4 * j)) & 28'hF);
            v[17 + j] = int'((opp_items >> (4 * j)) & 28'hF);
        end
        v[16] = int'(opp_handcuffed);
        v[24] = int'(self_handcuffed);
        for (int c = 0; c < 8; c++) v[25 + c] = int'((knowledge >> (2 * c)) & 16'h3);
        for (int i = 0; i < 33; i++) begin
            exp10[i] = scale(v[i], 10);
            exp12[i] = scale(v[i], 12);
        end
    endtask

    task automatic run_frame(input int scen, input bit stall, input bit perturb);
        int   cyc, nacc, mlp_seen;
        bit   was_stalled;
        logic [15:0] held_d;
        logic [5:0]  held_i;
        set_scen(scen);
        build_expected();
        for (int i = 0; i < 33; i++) begin got10[i] = 16'hDEAD; got12[i] = 16'hDEAD; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy10), 32'd1);
        if (perturb) set_scen(3);
        nacc = 0; cyc = 0; mlp_seen = 0; was_stalled = 1'b0;
        held_d = 16'd0; held_i = 6'd0;
        while (nacc < 33 && cyc < 400) begin
            check("valid_in_stream", 32'(feat10.feat_valid), 32'd1);
            check("feat_last", 32'(feat10.feat_last),
                  32'(feat10.feat_valid && feat10.feat_idx == 6'd32));
            if (was_stalled) begin
                check("stall_data", 32'(feat10.feat_data), 32'(held_d));
                check("stall_idx", 32'(feat10.feat_idx), 32'(held_i));
            end
            if (mlp_start10) mlp_seen++;
            start      = (perturb && nacc == 5) ? 1'b1 : 1'b0;
            feat_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (feat10.feat_valid && feat_ready) begin
                check("accept_idx", 32'(feat10.feat_idx), 32'(nacc));
                got10[nacc] = feat10.feat_data;
                got12[nacc] = feat12.feat_data;
                nacc++;
                was_stalled = 1'b0;
            end else begin
                was_stalled = feat10.feat_valid;
                held_d = feat10.feat_data;
                held_i = feat10.feat_idx;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        feat_ready = 1'b0;
        check("frame_complete", 32'(nacc), 32'd33);
        if (!stall) check("frame_cycles", 32'(cyc), 32'd33);
        check("mlp_early", 32'(mlp_seen), 32'd0);
        check("mlp_start_pulse", 32'(mlp_start10), 32'd1);
        check("mlp_start12_pulse", 32'(mlp_start12), 32'd1);
        check("valid_after_frame", 32'(feat10.feat_valid), 32'd0);
        @(negedge clk);
        check("mlp_start_one_cycle", 32'(mlp_start10), 32'd0);
        repeat (3) @(negedge clk);
        check("busy_in_wait", 32'(busy10), 32'd1);
        // start arrives with inference_done: release only, no new frame
        inference_done = 1'b1;
        start = 1'b1;
        @(negedge clk);
        inference_done = 1'b0;
        start = 1'b0;
        check("busy_released", 32'(busy10), 32'd0);
        @(negedge clk);
        check("no_restart_valid", 32'(feat10.feat_valid), 32'd0);
        check("no_restart_busy", 32'(busy10), 32'd0);
        for (int i = 0; i < 33; i++) begin
            check($sformatf("s%0d_w%0d_f10", scen, i), 32'(got10[i]), 32'(exp10[i]));
            check($sformatf("s%0d_w%0d_f12", scen, i), 32'(got12[i]), 32'(exp12[i]));
        end
        for (int t = 0; t < NTBL; t++) begin
            if (tbl[t].scen == scen) begin
                check($sformatf("tbl%0d_f10", t), 32'(got10[tbl[t].idx]), 32'(tbl[t].exp10));
                check($sformatf("tbl%0d_f12", t), 32'(got12[tbl[t].idx]), 32'(tbl[t].exp12));
            end
        end
    endtask

    initial begin
        int cyc;
        tbl[0]  = '{0, 0,  16'h0C00, 16'h3000};
        tbl[1]  = '{0, 1,  16'h0800, 16'h2000};
        tbl[2]  = '{0, 7,  16'h1000, 16'h4000};
        tbl[3]  = '{0, 8,  16'h1000, 16'h4000};
        tbl[4]  = '{1, 25, 16'h0000, 16'h0000};
        tbl[5]  = '{1, 26, 16'h0400, 16'h1000};
        tbl[6]  = '{1, 27, 16'h0800, 16'h2000};
        tbl[7]  = '{1, 28, 16'h0C00, 16'h3000};
        tbl[8]  = '{1, 29, 16'h0000, 16'h0000};
        tbl[9]  = '{1, 32, 16'h0000, 16'h0000};
        tbl[10] = '{2, 0,  16'h3C00, 16'h7FFF};
        tbl[11] = '{2, 1,  16'h1400, 16'h5000};
        tbl[12] = '{2, 2,  16'h1C00, 16'h7000};
        tbl[13] = '{2, 7,  16'h3C00, 16'h7FFF};
        tbl[14] = '{2, 8,  16'h1C00, 16'h7000};
        tbl[15] = '{2, 9,  16'h0400, 16'h1000};
        tbl[16] = '{2, 15, 16'h1C00, 16'h7000};
        tbl[17] = '{2, 16, 16'h0400, 16'h1000};
        tbl[18] = '{2, 17, 16'h2400, 16'h7FFF};
        tbl[19] = '{2, 23, 16'h3C00, 16'h7FFF};
        tbl[20] = '{2, 32, 16'h0C00, 16'h3000};

        rst_n = 1'b0;
        start = 1'b0;
        inference_done = 1'b0;
        feat_ready = 1'b0;
        set_scen(0);
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(feat10.feat_valid), 32'd0);
        check("rst_last", 32'(feat10.feat_last), 32'd0);
        check("rst_mlp_start", 32'(mlp_start10), 32'd0);
        check("rst_busy", 32'(busy10), 32'd0);
        check("rst_idx", 32'(feat10.feat_idx), 32'd0);
        check("rst_data", 32'(feat10.feat_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b0);
        run_frame(0, 1'b1, 1'b0);
        run_frame(2, 1'b0, 1'b1);

        // Abort mid-frame with async reset
        set_scen(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feat_ready = 1'b1;
        cyc = 0;
        while (feat10.feat_idx != 6'd10 && cyc < 50) begin
            check("abort_no_mlp", 32'(mlp_start10), 32'd0);
            @(negedge clk);
            cyc++;
        end
        check("abort_reach_idx10", 32'(feat10.feat_idx), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(feat10.feat_valid), 32'd0);
        check("abort_busy", 32'(busy10), 32'd0);
        check("abort_idx", 32'(feat10.feat_idx), 32'd0);
        check("abort_data", 32'(feat10.feat_data), 32'd0);
        check("abort_last", 32'(feat10.feat_last), 32'd0);
        feat_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_mlp_start", 32'(mlp_start10), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
